// File: rtl/ro_burst_buffer.sv
// ---------------------------------------------------------------------------
// ro_burst_buffer
//
// Upstream feeder for the PL-to-DDR AXI write master. Measurement samples are
// collected in a show-ahead FIFO. Once a full burst is buffered, a one-cycle
// start pulse is sent to the master. The master pops the burst and reports
// done/error, and this block checks the result.
//
// Optional feature: define RO_BURST_BUFFER_STATS_EN to add BURST_CNT, a
// 16-bit wrapping count of completed bursts.
//
// Ports
//   ACLK          in   sole clock, rising edge
//   ARESETN       in   asynchronous active-low reset
//   S_DATA        in   sample word from the measurement core
//   S_VALID       in   sample valid
//   S_READY       out  FIFO can accept a sample (registered)
//   M_RD_EN       in   master pops one word this cycle
//   M_RD_DATA     out  head-of-FIFO word (show-ahead, combinational)
//   INIT_AXI_TXN  out  one-cycle start pulse to the AXI master
//   TXN_DONE      in   master burst complete
//   TXN_ERROR     in   master error flag, sampled with TXN_DONE
//   BUSY          out  burst in flight
//   LEVEL         out  FIFO occupancy
//   ERR_STICKY    out  sticky transfer error (underrun, bad burst)
//   OVERFLOW      out  sticky: sample offered while S_READY low
//   BURST_CNT     out  completed bursts (only with RO_BURST_BUFFER_STATS_EN)
// ---------------------------------------------------------------------------
module ro_burst_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [DATA_WIDTH-1:0]     S_DATA,
  input  logic                      S_VALID,
  output logic                      S_READY,
  input  logic                      M_RD_EN,
  output logic [DATA_WIDTH-1:0]     M_RD_DATA,
  output logic                      INIT_AXI_TXN,
  input  logic                      TXN_DONE,
  input  logic                      TXN_ERROR,
  output logic                      BUSY,
  output logic [$clog2(DEPTH):0]    LEVEL,
  output logic                      ERR_STICKY,
  output logic                      OVERFLOW
`ifdef RO_BURST_BUFFER_STATS_EN
  ,
  output logic [15:0]               BURST_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // Pop counter is wider than the FIFO level so that an over-long burst
  // can never alias back onto BURST_LEN; it saturates instead of wrapping.
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_s_ready;
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_init;
  logic                  r_busy;
  logic [CW-1:0]         r_pop_cnt;
  logic                  r_err;
  logic                  r_ovf;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_underrun;
  logic [LW-1:0]         w_level_nxt;
  logic                  w_xfer_done;
  logic [CW:0]           w_pops_total;
  logic                  w_burst_bad;

  assign w_push      = S_VALID && r_s_ready;
  assign w_pop       = M_RD_EN && (r_level != {LW{1'b0}});
  assign w_underrun  = M_RD_EN && (r_level == {LW{1'b0}});
  assign w_xfer_done = (r_state == ST_XFER) && TXN_DONE;
  // A pop in the same cycle as TXN_DONE still belongs to the burst.
  assign w_pops_total = {1'b0, r_pop_cnt} + {{CW{1'b0}}, w_pop};
  assign w_burst_bad  = TXN_ERROR || (w_pops_total != (CW+1)'(BURST_LEN));

  assign S_READY      = r_s_ready;
  assign M_RD_DATA    = r_mem[r_rd_ptr];
  assign INIT_AXI_TXN = r_init;
  assign BUSY         = r_busy;
  assign LEVEL        = r_level;
  assign ERR_STICKY   = r_err;
  assign OVERFLOW     = r_ovf;

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Burst sequencing: wait for a full burst, pulse start, wait for done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_level >= LW'(BURST_LEN)) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: w_state_nxt = ST_XFER;
      ST_XFER: begin
        if (TXN_DONE) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_XFER;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO storage; contents are not reset, only the pointers are.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= S_DATA;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_level   <= {LW{1'b0}};
      r_s_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level   <= w_level_nxt;
      r_s_ready <= (w_level_nxt != LW'(DEPTH));
    end
  end

  // State register plus start pulse and busy, registered from next state.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_IDLE;
      r_init  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= (w_state_nxt == ST_START);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Pops within the current burst: cleared in START, counted in XFER.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pop_cnt <= {CW{1'b0}};
    end else if (r_state == ST_START) begin
      r_pop_cnt <= {CW{1'b0}};
    end else if ((r_state == ST_XFER) && w_pop && (r_pop_cnt != {CW{1'b1}})) begin
      r_pop_cnt <= r_pop_cnt + CW'(1);
    end
  end

  // Sticky error and overflow flags, cleared only by reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_underrun || (w_xfer_done && w_burst_bad)) begin
        r_err <= 1'b1;
      end
      if (S_VALID && !r_s_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef RO_BURST_BUFFER_STATS_EN
  logic [15:0] r_burst_cnt;

  assign BURST_CNT = r_burst_cnt;

  // Completed-burst counter, wraps naturally at 16 bits.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_burst_cnt <= 16'd0;
    end else if (w_xfer_done) begin
      r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end
`endif

endmodule
